// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode and phase encodings plus the ALU-op test.
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_HLT = 3'b000,
      OP_SKZ = 3'b001,
      OP_ADD = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100,
      OP_LDA = 3'b101,
      OP_STO = 3'b110,
      OP_JMP = 3'b111
   } opcode_t;

   typedef enum logic [2:0] {
      PH_INST_ADDR  = 3'd0,
      PH_INST_FETCH = 3'd1,
      PH_INST_LOAD  = 3'd2,
      PH_IDLE       = 3'd3,
      PH_OP_ADDR    = 3'd4,
      PH_OP_FETCH   = 3'd5,
      PH_ALU_OP     = 3'd6,
      PH_STORE      = 3'd7
   } phase_t;

   // Opcodes whose result lands in the accumulator (they read an operand).
   function automatic logic is_aluop(opcode_t op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/phase_counter.sv
// 3-bit free-running phase counter with a hold (enable) input.
module phase_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [2:0] phase
);

   logic [2:0] cnt_q;
   logic [2:0] cnt_d;

   // Advance by one when enabled; wraps 7 -> 0 naturally.
   always_comb begin
      cnt_d = cnt_q;
      if (en) cnt_d = cnt_q + 3'd1;
   end

   // Counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 3'd0;
      else        cnt_q <= cnt_d;
   end

   assign phase = cnt_q;

endmodule

// File: rtl/controller.sv
// Eight-phase instruction sequencer: decodes phase/opcode/zero into strobes.
module controller
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       halt,
   output logic       ld_pc,
   output logic       data_e,
   output logic       ld_ac,
   output logic       wr,
   output logic [2:0] phase
);

   opcode_t    op;
   phase_t     ph;
   logic [2:0] cnt;
   logic       halted_q;
   logic       halted_d;
   logic       halt_now;
   logic       alu;

   assign op  = opcode_t'(opcode);
   assign ph  = phase_t'(cnt);
   assign alu = is_aluop(op);

   // HLT is recognised in OP_ADDR; the counter must hold on that very edge.
   assign halt_now = (ph == PH_OP_ADDR) && (op == OP_HLT);

   // Sticky halt: once set only reset clears it.
   always_comb begin
      halted_d = halted_q | halt_now;
   end

   // Halted flag state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) halted_q <= 1'b0;
      else      halted_q <= halted_d;
   end

   phase_counter u_phase (
      .clk   (clk),
      .rst_n (rst),
      .en    (!halted_d),
      .phase (cnt)
   );

   // Moore in phase, combinational in opcode/zero; zero only matters in ALU_OP.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      halt   = halted_q;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      case (ph)
         PH_INST_ADDR:  sel = 1'b1;
         PH_INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         PH_INST_LOAD, PH_IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         PH_OP_ADDR: begin
            inc_pc = !halted_q;
            halt   = halted_q | (op == OP_HLT);
         end
         PH_OP_FETCH:   rd = alu;
         PH_ALU_OP: begin
            rd     = alu;
            inc_pc = (op == OP_SKZ) && zero;
            ld_pc  = (op == OP_JMP);
            data_e = (op == OP_STO);
         end
         PH_STORE: begin
            rd     = alu;
            ld_ac  = alu;
            ld_pc  = (op == OP_JMP);
            wr     = (op == OP_STO);
            data_e = (op == OP_STO);
         end
         default: ;
      endcase
   end

   assign phase = cnt;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench: driver pushes predicted outputs, monitor pops and compares.
module tb_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
   logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
   logic [2:0] phase;

   always #5 clk = ~clk;

   controller dut (
      .clk    (clk),
      .rst    (rst),
      .opcode (opcode),
      .zero   (zero),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .halt   (halt),
      .ld_pc  (ld_pc),
      .data_e (data_e),
      .ld_ac  (ld_ac),
      .wr     (wr),
      .phase  (phase)
   );

   typedef struct packed {
      logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
      logic [2:0] phase;
   } outs_t;

   outs_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    m_phase  = 0;
   bit    m_halted = 0;

   // Reference: one instruction = 8 numbered phases, rules from the opcode table.
   function automatic outs_t model(int ph, int op, bit z, bit hd);
      outs_t o;
      bit alu   = (op == 2) || (op == 3) || (op == 4) || (op == 5);
      bit late  = (ph == 6) || (ph == 7);
      o.sel    = (ph <= 3);
      o.rd     = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      o.ld_ir  = (ph == 2) || (ph == 3);
      o.inc_pc = (ph == 4 && !hd) || (ph == 6 && op == 1 && z);
      o.halt   = hd || (ph == 4 && op == 0);
      o.ld_pc  = late && (op == 7);
      o.data_e = late && (op == 6);
      o.ld_ac  = (ph == 7) && alu;
      o.wr     = (ph == 7) && (op == 6);
      o.phase  = 3'(ph);
      return o;
   endfunction

   function automatic outs_t sample();
      outs_t o;
      o = '{sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase};
      return o;
   endfunction

   task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%b exp=%b (sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr phase[3])",
                    name, got, exp);
   endtask

   // One clock: apply the edge to the model with the old inputs, then drive new ones.
   task automatic tick(input logic [2:0] op_n, input logic z_n, input logic rst_v);
      @(posedge clk);
      #1;
      if (rst === 1'b1 && !m_halted) begin
         if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
         else                               m_phase  = (m_phase + 1) % 8;
      end
      rst    = rst_v;
      opcode = op_n;
      zero   = z_n;
      if (!rst_v) begin
         m_phase  = 0;
         m_halted = 1'b0;
      end
      exp_q.push_back(model(m_phase, int'(opcode), zero, m_halted));
   endtask

   // zmode: 0/1 hold zero at that value, 2 randomise zero every clock.
   task automatic run_instr(input logic [2:0] op, input int zmode);
      for (int i = 0; i < 8; i++)
         tick(op, (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1), 1'b1);
      if (op == 3'd0) begin
         tick(op, 1'b0, 1'b0);
         tick(op, 1'b0, 1'b1);
      end
   endtask

   // Monitor: every cycle the DUT presents outputs; compare to the oldest prediction.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         outs_t e;
         outs_t g;
         e = exp_q.pop_front();
         g = sample();
         check($sformatf("outs@ph%0d", e.phase), g, e);
         if (g.wr && g.ld_ac)     check("wr_ld_ac_excl", 12'(g), 12'(g) ^ 12'h001);
         if (g.ld_pc && g.inc_pc) check("ldpc_incpc_excl", 12'(g), 12'(g) ^ 12'h001);
      end
   end

   initial begin
      int guard;
      rst    = 1'b0;
      opcode = 3'd0;
      zero   = 1'b0;

      // Reset held, then released: phase stays 0 until the first edge after release.
      tick(3'd0, 1'b0, 1'b0);
      tick(3'd0, 1'b0, 1'b0);
      tick(3'd5, 1'b0, 1'b1);

      run_instr(3'd5, 2);   // LDA
      run_instr(3'd6, 2);   // STO
      run_instr(3'd1, 1);   // SKZ, zero=1
      run_instr(3'd1, 0);   // SKZ, zero=0
      run_instr(3'd7, 2);   // JMP

      // ADD, reset asserted in the middle of ALU_OP.
      for (int i = 0; i < 6; i++) tick(3'd2, 1'($urandom_range(0, 1)), 1'b1);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      m_phase  = 0;
      m_halted = 1'b0;
      check("rst_abort_add", sample(), model(0, 2, zero, 1'b0));
      tick(3'd2, 1'b0, 1'b1);

      // HLT: freeze in OP_ADDR for 20 clocks, then a reset pulse.
      for (int i = 0; i < 24; i++) tick(3'd0, 1'($urandom_range(0, 1)), 1'b1);
      tick(3'd0, 1'b0, 1'b0);
      tick(3'd0, 1'b0, 1'b1);

      // Randomised instruction stream.
      for (int n = 0; n < 40; n++) run_instr(3'($urandom_range(0, 7)), 2);

      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
